// File: rtl/rr_lock_arbiter.sv
// Round-robin lock arbiter: one requester at a time holds the resource until it
// finishes, drops its request, or exceeds MAX_HOLD cycles (forced release).
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no grant; next edge grants the first requester at/after ptr
//   ST_GRANT | one requester owns the resource; hold_cnt counts held cycles
module rr_lock_arbiter #(
    parameter int WID      = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [WID-1:0]         req_i,
    input  logic                   done_i,
    output logic [WID-1:0]         gnt_o,
    output logic                   gnt_valid_o,
    output logic [$clog2(WID)-1:0] gnt_id_o,
    output logic                   timeout_o
);

    localparam int IDW = $clog2(WID);
    localparam int CW  = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    hold_q, hold_d;
    logic [WID-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             tmo_q, tmo_d;

    logic [WID-1:0]   mask_hi;
    logic [WID-1:0]   req_hi;
    logic [IDW-1:0]   pick_hi;
    logic [IDW-1:0]   pick_lo;
    logic [IDW-1:0]   pick_id;
    logic             req_held;
    logic [IDW-1:0]   ptr_next;

    // Cyclic search from ptr: prefer the lowest request at or above ptr,
    // otherwise wrap to the lowest request overall.
    always_comb begin
        mask_hi = ~((WID'(1) << ptr_q) - WID'(1));
        req_hi  = req_i & mask_hi;
        pick_hi = '0;
        pick_lo = '0;
        for (int i = WID - 1; i >= 0; i--) begin
            if (req_hi[i]) pick_hi = IDW'(i);
            if (req_i[i])  pick_lo = IDW'(i);
        end
        pick_id = (|req_hi) ? pick_hi : pick_lo;
    end

    assign req_held = |(req_i & gnt_q);
    assign ptr_next = (gnt_id_q == IDW'(WID - 1)) ? '0 : gnt_id_q + IDW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            hold_q   <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        tmo_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d  = ST_GRANT;
                    gnt_d    = WID'(1) << pick_id;
                    gnt_id_d = pick_id;
                    hold_d   = '0;
                end
            end
            ST_GRANT: begin
                // A normal release wins over a coincident hold expiry.
                if (done_i || !req_held || hold_q == HOLD_LAST) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    hold_d   = '0;
                    ptr_d    = ptr_next;
                    tmo_d    = !(done_i || !req_held);
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                hold_d   = '0;
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = gnt_id_q;
    assign gnt_valid_o = (state_q == ST_GRANT);
    assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (WID=8, MAX_HOLD=16) with hand-computed
// expected grant sequences.
module tb_rr_lock_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] req_i;
    logic       done_i;
    logic [7:0] gnt_o;
    logic       gnt_valid_o;
    logic [2:0] gnt_id_o;
    logic       timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    rr_lock_arbiter #(.WID(8), .MAX_HOLD(16)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .done_i      (done_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_id_o    (gnt_id_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Packs {timeout, valid, id, gnt} so one comparison covers every output.
    task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                              input logic to);
        check_eq(tag, {19'd0, timeout_o, gnt_valid_o, gnt_id_o, gnt_o},
                 {19'd0, to, (g != 8'h00), id, g});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset held with full request vector
        rst_ni = 1'b0;
        req_i  = 8'hFF;
        done_i = 1'b0;
        tick(); expect_out("rst_c1", 8'h00, 3'd0, 1'b0);
        tick(); expect_out("rst_c2", 8'h00, 3'd0, 1'b0);
        rst_ni = 1'b1;
        tick(); expect_out("rst_first_gnt", 8'h01, 3'd0, 1'b0);

        // Fairness: order 1..7 then wrap to 0, one bubble between grants
        done_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(); expect_out($sformatf("fair_idle%0d", k), 8'h00, 3'd0, 1'b0);
            tick(); expect_out($sformatf("fair_gnt%0d", k), 8'h01 << (k % 8), 3'((k % 8)), 1'b0);
        end

        // Reset during a grant, then cyclic search with req 0x81 from ptr 0
        rst_ni = 1'b0;
        tick(); expect_out("rst_in_grant", 8'h00, 3'd0, 1'b0);
        rst_ni = 1'b1;
        req_i  = 8'h81;
        tick(); expect_out("cyc_gnt0", 8'h01, 3'd0, 1'b0);
        tick(); expect_out("cyc_idle0", 8'h00, 3'd0, 1'b0);
        tick(); expect_out("cyc_gnt7", 8'h80, 3'd7, 1'b0);
        tick(); expect_out("cyc_idle7", 8'h00, 3'd0, 1'b0);
        tick(); expect_out("cyc_wrap_gnt0", 8'h01, 3'd0, 1'b0);

        // Request drop releases bit 0; then a held bit 2 times out after 16 cycles
        req_i  = 8'h04;
        done_i = 1'b0;
        tick(); expect_out("drop0_idle", 8'h00, 3'd0, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            tick(); expect_out($sformatf("to_hold%0d", c), 8'h04, 3'd2, 1'b0);
        end
        tick(); expect_out("to_pulse", 8'h00, 3'd0, 1'b1);
        tick(); expect_out("to_regrant", 8'h04, 3'd2, 1'b0);

        // Grant bit 3, then drop only req[3]: ptr must move to 4
        req_i = 8'h08;
        tick(); expect_out("drop2_idle", 8'h00, 3'd0, 1'b0);
        tick(); expect_out("gnt3", 8'h08, 3'd3, 1'b0);
        req_i = 8'hF7;
        tick(); expect_out("drop3_idle", 8'h00, 3'd0, 1'b0);
        tick(); expect_out("ptr4_gnt4", 8'h10, 3'd4, 1'b0);

        // done_i coincides with the last allowed hold cycle: no timeout pulse
        for (int c = 2; c <= 16; c++) begin
            tick(); expect_out($sformatf("col_hold%0d", c), 8'h10, 3'd4, 1'b0);
        end
        done_i = 1'b1;
        tick(); expect_out("col_release", 8'h00, 3'd0, 1'b0);
        done_i = 1'b0;
        tick(); expect_out("col_gnt5", 8'h20, 3'd5, 1'b0);

        // Reset in cycle 5 of a bit-6 grant
        req_i = 8'h40;
        tick(); expect_out("drop5_idle", 8'h00, 3'd0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            tick(); expect_out($sformatf("g6_hold%0d", c), 8'h40, 3'd6, 1'b0);
        end
        rst_ni = 1'b0;
        tick(); expect_out("g6_rst", 8'h00, 3'd0, 1'b0);
        rst_ni = 1'b1;
        tick(); expect_out("g6_after_rst", 8'h40, 3'd6, 1'b0);

        // Nothing requested: stay idle with zero outputs
        req_i  = 8'h00;
        done_i = 1'b1;
        tick(); expect_out("empty_release", 8'h00, 3'd0, 1'b0);
        tick(); expect_out("empty_idle", 8'h00, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
